// File: rtl/demux_lane_pkg.sv
// Shared constants, read-FSM state type and lane-vector helpers for demux_lane_counter.
package demux_lane_pkg;

   localparam int LANES      = 8;
   localparam int LANE_IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } rd_state_e;

   // True when more than one lane bit is set.
   function automatic logic multi_hot(input logic [LANES-1:0] v);
      return ((v & (v - 8'd1)) != 8'd0);
   endfunction

   function automatic logic [LANE_IDX_W-1:0] lowest_idx(input logic [LANES-1:0] v);
      logic [LANE_IDX_W-1:0] idx;
      idx = 3'd0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (v[k]) begin
            idx = k[LANE_IDX_W-1:0];
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/demux_lane_edge_cnt.sv
// One demux lane: registers the lane, detects its rising edge and counts rises
// in a saturating counter with synchronous clear and an external increment enable.
module demux_lane_edge_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             lane,
   input  logic             inc_en,
   output logic [CNT_W-1:0] cnt
);

   logic             lane_q_r;
   logic [CNT_W-1:0] cnt_r;
   logic             rise_s;
   logic             sat_s;

   assign rise_s = lane & ~lane_q_r;
   assign sat_s  = &cnt_r;

   // Lane history and saturating rise counter; clear beats an increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q_r <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         lane_q_r <= lane;
         if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (rise_s && inc_en && !sat_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/demux_lane_counter.sv
// Per-lane rise counters behind a 1x8 demux, with any/active encoder and a
// request/acknowledge read port. Define DEMUX_LANE_CNT_ERR_EN for multi-hot detection.
module demux_lane_counter
   import demux_lane_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LANES-1:0]      y,
   input  logic                  clr,
   input  logic                  rd_req,
   input  logic [LANE_IDX_W-1:0] rd_addr,
   output logic                  rd_ack,
   output logic [CNT_W-1:0]      rd_data,
   output logic                  any,
   output logic [LANE_IDX_W-1:0] active,
   output logic                  err
);

   logic [CNT_W-1:0]      cnt_s [LANES];
   logic                  inc_en_s;
   rd_state_e             state_r;
   rd_state_e             state_nxt_s;
   logic                  snap_s;
   logic                  rd_ack_r;
   logic [CNT_W-1:0]      rd_data_r;
   logic                  any_r;
   logic [LANE_IDX_W-1:0] active_r;

`ifdef DEMUX_LANE_CNT_ERR_EN
   logic err_r;
   logic multi_s;

   assign multi_s  = multi_hot(y);
   assign inc_en_s = ~multi_s;

   // Sticky multi-hot flag, cleared only by clr or reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (clr) begin
         err_r <= 1'b0;
      end else if (multi_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err = err_r;
`else
   assign inc_en_s = 1'b1;
   assign err      = 1'b0;
`endif

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      demux_lane_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (clr),
         .lane   (y[g]),
         .inc_en (inc_en_s),
         .cnt    (cnt_s[g])
      );
   end

   // Registered lane-activity encoder; lowest index wins on multi-hot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         any_r    <= 1'b0;
         active_r <= 3'd0;
      end else begin
         any_r    <= |y;
         active_r <= lowest_idx(y);
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Read FSM next state; ACK returns straight to IDLE if the request already dropped.
   always_comb begin
      state_nxt_s = state_r;
      snap_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (rd_req) begin
               state_nxt_s = ACK;
               snap_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACK: begin
            if (rd_req) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (rd_req) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Ack pulse and snapshot of the pre-update counter value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ack_r  <= 1'b0;
         rd_data_r <= {CNT_W{1'b0}};
      end else begin
         rd_ack_r <= snap_s;
         if (snap_s) begin
            rd_data_r <= cnt_s[rd_addr];
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign rd_ack  = rd_ack_r;
   assign rd_data = rd_data_r;
   assign any     = any_r;
   assign active  = active_r;

endmodule

// File: tb/tb_demux_lane_counter.sv
// Directed self-checking bench for demux_lane_counter (CNT_W=4); expectations follow
// DEMUX_LANE_CNT_ERR_EN when it is defined for the build.
module tb_demux_lane_counter;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [7:0]       y;
   logic             clr;
   logic             rd_req;
   logic [2:0]       rd_addr;
   logic             rd_ack;
   logic [CNT_W-1:0] rd_data;
   logic             any;
   logic [2:0]       active;
   logic             err;

   int n_cmp;
   int n_bad;

   demux_lane_counter #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .y       (y),
      .clr     (clr),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .rd_ack  (rd_ack),
      .rd_data (rd_data),
      .any     (any),
      .active  (active),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] mask);
      y = mask;
      tick();
      y = 8'h00;
      tick();
   endtask

   task automatic clear_all();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   // Issue one read and wait (bounded) for its ack.
   task automatic read_lane(input logic [2:0] a, output int val);
      bit got;
      got     = 1'b0;
      val     = -1;
      rd_req  = 1'b1;
      rd_addr = a;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rd_ack && !got) begin
            got = 1'b1;
            val = int'(rd_data);
            break;
         end
      end
      rd_req = 1'b0;
      tick();
      tick();
      if (!got) check("rd_timeout", 0, 1);
   endtask

   int v;
   int acks;
   int exp_mh;

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      y       = 8'h04;
      clr     = 1'b0;
      rd_req  = 1'b0;
      rd_addr = 3'd0;

      // Reset held two cycles with lane 2 high
      tick();
      tick();
      check("rst_ack", int'(rd_ack), 0);
      check("rst_data", int'(rd_data), 0);
      check("rst_any", int'(any), 0);
      check("rst_active", int'(active), 0);
      check("rst_err", int'(err), 0);
      y     = 8'h00;
      rst_n = 1'b1;
      tick();
      read_lane(3'd2, v);
      check("rst_lane2", v, 0);

      // Select sweep: each lane 2 cycles high, 1 cycle idle
      for (int s = 0; s < 8; s++) begin
         y = 8'h01 << s;
         tick();
         check($sformatf("sweep_active%0d", s), int'(active), s);
         check($sformatf("sweep_any%0d", s), int'(any), 1);
         tick();
         y = 8'h00;
         tick();
      end
      for (int s = 0; s < 8; s++) begin
         read_lane(s[2:0], v);
         check($sformatf("sweep_cnt%0d", s), v, 1);
      end

      // Multi-hot
      clear_all();
`ifdef DEMUX_LANE_CNT_ERR_EN
      exp_mh = 0;
`else
      exp_mh = 1;
`endif
      y = 8'h81;
      tick();
      y = 8'h00;
      check("mh_err", int'(err), 1 - exp_mh);
      check("mh_active", int'(active), 0);
      tick();
      read_lane(3'd0, v);
      check("mh_lane0", v, exp_mh);
      read_lane(3'd7, v);
      check("mh_lane7", v, exp_mh);
      clear_all();
      check("mh_err_clr", int'(err), 0);

      // clr coincident with a rise on lane 5
      pulse(8'h20);
      pulse(8'h20);
      y   = 8'h20;
      clr = 1'b1;
      tick();
      y   = 8'h00;
      clr = 1'b0;
      tick();
      read_lane(3'd5, v);
      check("coll_clr", v, 0);

      // Read coincident with a rise on lane 5
      pulse(8'h20);
      pulse(8'h20);
      y       = 8'h20;
      rd_req  = 1'b1;
      rd_addr = 3'd5;
      tick();
      check("coll_rd_ack", int'(rd_ack), 1);
      check("coll_rd_data", int'(rd_data), 2);
      y      = 8'h00;
      rd_req = 1'b0;
      tick();
      tick();
      read_lane(3'd5, v);
      check("coll_next", v, 3);
      clear_all();
      tick();
      check("clr_keeps_data", int'(rd_data), 3);

      // Level held 10 cycles counts once
      y = 8'h10;
      for (int i = 0; i < 10; i++) tick();
      y = 8'h00;
      tick();
      read_lane(3'd4, v);
      check("level_lane4", v, 1);

      // Request held 5 cycles gives exactly one ack
      acks    = 0;
      rd_req  = 1'b1;
      rd_addr = 3'd4;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rd_ack) acks++;
      end
      rd_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rd_ack) acks++;
      end
      check("held_req_acks", acks, 1);

      // Saturation at 2^4-1
      for (int i = 0; i < 20; i++) pulse(8'h08);
      read_lane(3'd3, v);
      check("sat_lane3", v, 15);

      // Reset asserted with a request: no ack
      acks    = 0;
      rd_req  = 1'b1;
      rd_addr = 3'd3;
      rst_n   = 1'b0;
      tick();
      if (rd_ack) acks++;
      tick();
      if (rd_ack) acks++;
      rd_req = 1'b0;
      rst_n  = 1'b1;
      tick();
      if (rd_ack) acks++;
      check("rst_abort_acks", acks, 0);
      read_lane(3'd3, v);
      check("rst_abort_lane3", v, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux_lane_counter.md
# demux_lane_counter

Per-lane event counter that sits directly downstream of the 1x8 demultiplexer and consumes its one-hot `y[7:0]` output. It registers the lane outputs, counts rising edges per lane in saturating counters, and flags illegal multi-hot input. Counts are read back through a single-request/acknowledge read port, so a bench or host can confirm that demux select sweeps reach the correct lanes.

## Interface
- `CNT_W`, default 8: width of each lane counter; legal range 2..16.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset, sampled on `clk`.
- `y  in  8`: lane outputs of the 1x8 demux; `y[k]` is lane k.
- `clr  in  1`: synchronous clear of all counters and `err`.
- `rd_req  in  1`: read request, level; sampled only in IDLE.
- `rd_addr  in  3`: lane to read; captured with `rd_req`.
- `rd_ack  out  1`: one-cycle pulse; `rd_data` is valid in that cycle.
- `rd_data  out  CNT_W`: snapshot of the addressed counter; held until the next ack.
- `any  out  1`: registered OR of `y`.
- `active  out  3`: registered binary index of the asserted lane; 0 when `any`=0.
- `err  out  1`: sticky multi-hot flag.

## Operation
- `y_q` is `y` registered each cycle. Per-lane rise is `y & ~y_q`.
- Each counter increments by 1 on its lane's rise and saturates at 2^CNT_W-1. There is no wrap-around.
- A lane held high for N cycles counts once.
- Read FSM has three states:
  - IDLE: on `rd_req`=1, capture `rd_addr`, snapshot the counter, then go to ACK.
  - ACK: `rd_ack`=1 for this cycle only, then go to WAIT.
  - WAIT: stay until `rd_req`=0, then go to IDLE.
  - A request held high therefore yields exactly one ack.
- Priority within one cycle:
  - `clr` beats an increment; the counter ends at 0.
  - A snapshot taken in the same cycle as an increment or a `clr` returns the pre-update value.
- `active` for multi-hot `y_q`: lowest set index.

## Timing
- Reset (`rst_n`=0 at an edge): counters, `y_q`, `err`, `rd_ack`, `rd_data`, `any` and `active` go to 0; FSM goes to IDLE.
- `y_q` resets to 0. A lane high at the first edge after reset release therefore counts as a rise.
- Increment latency: a rise sampled at edge k is visible in the counter after edge k. A read requested at edge k+1 returns the new value.
- Read latency: `rd_req` sampled at edge k in IDLE gives `rd_ack`/`rd_data` valid during the cycle after edge k. The earliest next accepted request is at edge k+2, and only if `rd_req` has dropped.
- `any`/`active` lag `y` by one cycle.
- Reset mid-read aborts the read; no ack is issued.
- `clr` does not affect the FSM or `rd_data`.

## Configuration
- `DEMUX_LANE_CNT_ERR_EN` defined:
  - When popcount(`y`) > 1 at an edge, set sticky `err`.
  - Suppress all increments at that edge.
  - `err` is cleared only by `clr` or reset.
- Undefined:
  - `err` is tied to 0 and no multi-hot check exists.
  - Every rising lane increments independently, including in multi-hot cycles.

## Structure
- Package `demux_lane_pkg` holds:
  - constant `LANES` = 8
  - constant `LANE_IDX_W` = 3
  - read FSM state enum {IDLE, ACK, WAIT}
- Sub-module `demux_lane_edge_cnt` covers one lane: edge detect, saturating counter, `clr`, and an increment-enable input used for multi-hot suppression. It is instantiated 8 times.
- The top level holds the multi-hot check, the `any`/`active` encoder, and the read FSM/mux.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `y`=8'h04 → every output reads 0. Release with `y`=8'h00 → no count.
- **Select sweep:** drive the demux with i=1 and s=000..111, each select for 2 cycles and i=0 for 1 cycle between → reading lanes 0..7 returns 1 each; `active` tracks s one cycle late.
- **Saturation (`CNT_W`=4):** apply 20 single-cycle pulses on `y[3]` → read lane 3 returns 15.
- **Multi-hot (macro defined):** `y`=8'h81 for one cycle → `err`=1 and lanes 0 and 7 read 0. Pulse `clr` → `err`=0.
- **Collisions:**
  - Lane 5 at 2, `clr` coincident with a rise → read returns 0.
  - Lane 5 at 2, read request coincident with a rise → `rd_data`=2, and the next read returns 3.
- **Levels:** `y`=8'h10 held for 10 cycles → lane 4 reads 1. `rd_req` held for 5 cycles → exactly one `rd_ack` pulse.
